// File: rtl/mul_issue_pkg.sv
// Shared types and defaults for the multiplier issue controller slice.
package mul_issue_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 4;

    // Issue/collect sequencing: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // One queued operation at the default widths
    typedef struct packed {
        logic [N_DEF-1:0]     a;
        logic [N_DEF-1:0]     b;
        logic [TAG_W_DEF-1:0] tag;
    } op_t;

    // 32-bit saturating increment used by the statistics counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous FIFO of operations. Pointers wrap modulo DEPTH (power of two);
// a separate count register tracks occupancy 0..DEPTH. Full/empty are
// registered from the next count so they are clean flop outputs.
// No bypass: an entry becomes poppable the cycle after its push.
module mul_op_fifo
    import mul_issue_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = op_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic            full_r;
    logic            empty_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify requests against the flags so overflow/underflow cannot corrupt state
    always_comb begin
        push_ok_s    = push && !full_r;
        pop_ok_s     = pop && !empty_r;
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == {CW{1'b0}});
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Feeder/collector around seq_multiplier: buffers operand pairs, issues one
// at a time with a single-cycle start pulse, captures the product on done and
// holds it with its tag until the consumer accepts it.
// Optional build macro MUL_ISSUE_STATS_EN adds saturating stat_ops and
// stat_stall counters.
module mul_issue_ctrl
    import mul_issue_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [N-1:0]     mul_multiplicand,
    output logic [N-1:0]     mul_multiplier,
    input  logic             mul_busy,
    input  logic             mul_done,
    input  logic [2*N-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [TAG_W-1:0] tag;
    } op_loc_t;

    op_loc_t           push_data_s;
    op_loc_t           head_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;

    state_t            state_r;
    state_t            next_state_s;
    logic [N-1:0]      op_a_r;
    logic [N-1:0]      op_b_r;
    logic [TAG_W-1:0]  op_tag_r;
    logic              mul_start_r;
    logic              out_valid_r;
    logic [2*N-1:0]    out_product_r;
    logic [TAG_W-1:0]  out_tag_r;

    assign push_s      = in_valid && !fifo_full_s;
    assign push_data_s = '{a: in_a, b: in_b, tag: in_tag};

    mul_op_fifo #(
        .DEPTH (DEPTH),
        .T     (op_loc_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Next-state and pop decision; the head is taken only when the flag and counter agree
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && (fifo_count_s != {CW{1'b0}}) && !mul_busy) begin
                    pop_s        = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, operand capture, start pulse and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            op_a_r        <= {N{1'b0}};
            op_b_r        <= {N{1'b0}};
            op_tag_r      <= {TAG_W{1'b0}};
            mul_start_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*N){1'b0}};
            out_tag_r     <= {TAG_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            mul_start_r <= pop_s;
            if (pop_s) begin
                op_a_r   <= head_s.a;
                op_b_r   <= head_s.b;
                op_tag_r <= head_s.tag;
            end
            if ((state_r == WAIT) && mul_done) begin
                out_product_r <= mul_product;
                out_tag_r     <= op_tag_r;
                out_valid_r   <= 1'b1;
            end else if ((state_r == HOLD) && out_ready) begin
                out_valid_r   <= 1'b0;
            end
        end
    end

    assign in_ready         = !fifo_full_s;
    assign mul_start        = mul_start_r;
    assign mul_multiplicand = op_a_r;
    assign mul_multiplier   = op_b_r;
    assign out_valid        = out_valid_r;
    assign out_product      = out_product_r;
    assign out_tag          = out_tag_r;

`ifdef MUL_ISSUE_STATS_EN
    logic [31:0] stat_ops_r;
    logic [31:0] stat_stall_r;

    // Saturating counters: completed result handshakes and input stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_r   <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (out_valid_r && out_ready) begin
                stat_ops_r <= sat_inc32(stat_ops_r);
            end
            if (in_valid && fifo_full_s) begin
                stat_stall_r <= sat_inc32(stat_stall_r);
            end
        end
    end

    assign stat_ops   = stat_ops_r;
    assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a behavioural sequential-multiplier model of
// random latency and an in-order scoreboard of {a*b, tag} built from accepted pushes.
module tb_mul_issue_ctrl;

    localparam int N     = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mul_start;
    logic [N-1:0]     mul_multiplicand;
    logic [N-1:0]     mul_multiplier;
    logic             mul_busy;
    logic             mul_done;
    logic [2*N-1:0]   mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_product;
    logic [TAG_W-1:0] out_tag;
`ifdef MUL_ISSUE_STATS_EN
    logic [31:0]      stat_ops;
    logic [31:0]      stat_stall;
`endif

    mul_issue_ctrl #(.N(N), .DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_tag           (in_tag),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_busy         (mul_busy),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_tag          (out_tag)
`ifdef MUL_ISSUE_STATS_EN
        ,
        .stat_ops         (stat_ops),
        .stat_stall       (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: captures operands on start, done after a random latency
    logic [N-1:0] cap_a, cap_b;
    int           lat_cnt;
    int           force_lat = 0;
    always @(posedge clk) begin
        if (rst) begin
            mul_busy    <= 1'b0;
            mul_done    <= 1'b0;
            lat_cnt     <= 0;
            mul_product <= 64'd0;
        end else begin
            mul_done    <= 1'b0;
            mul_product <= {$urandom, $urandom};
            if (mul_start) begin
                mul_busy <= 1'b1;
                cap_a    <= mul_multiplicand;
                cap_b    <= mul_multiplier;
                lat_cnt  <= (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
            end else if (mul_busy) begin
                if (lat_cnt <= 1) begin
                    mul_done    <= 1'b1;
                    mul_busy    <= 1'b0;
                    mul_product <= {32'd0, cap_a} * {32'd0, cap_b};
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    // Reference model: in-order queue of expected results
    logic [63:0]      exp_prod_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    int               n_results = 0;
    int               n_starts  = 0;
    int               push_cyc, start_cyc, done_cyc, valid_cyc;
    logic [63:0]      last_prod;
    logic [TAG_W-1:0] last_tag;
    logic             hold_prev = 1'b0;
    logic             prev_valid = 1'b0;
    logic [63:0]      held_prod;
    logic [TAG_W-1:0] held_tag;

    // Monitor on the falling edge, away from register updates
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_prod_q.push_back({32'd0, in_a} * {32'd0, in_b});
                exp_tag_q.push_back(in_tag);
                push_cyc = cyc;
            end
            if (mul_start) begin
                n_starts++;
                start_cyc = cyc;
                check_eq("start_while_result_held", 64'(out_valid), 64'd0);
            end
            if (mul_done) done_cyc = cyc;
            if (out_valid && !prev_valid) valid_cyc = cyc;
            if (hold_prev && out_valid) begin
                check_eq("hold_product_stable", out_product, held_prod);
                check_eq("hold_tag_stable", 64'(out_tag), 64'(held_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_prod_q.size() == 0) begin
                    check_eq("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check_eq("result_product", out_product, exp_prod_q.pop_front());
                    check_eq("result_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
                end
                last_prod = out_product;
                last_tag  = out_tag;
                n_results++;
            end
            hold_prev  = out_valid && !out_ready;
            held_prod  = out_product;
            held_tag   = out_tag;
            prev_valid = out_valid;
        end else begin
            hold_prev  = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // Offer one op; called and returns at posedge+1; reports cycles spent stalled
    task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [TAG_W-1:0] t, output int waited);
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) begin
                check_eq("push_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int k = 0;
        while (n_results < target && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("result_arrival", 64'(n_results >= target), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int base;
        int s0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_mul_start", 64'(mul_start), 64'd0);
        check_eq("reset_out_product", out_product, 64'd0);
        check_eq("reset_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Single op and latencies
        base = n_results;
        push_op(32'd3, 32'd5, 4'd2, w);
        wait_results(base + 1);
        check_eq("push_to_start_latency", 64'(start_cyc - push_cyc), 64'd2);
        check_eq("done_to_valid_latency", 64'(valid_cyc - done_cyc), 64'd1);
        check_eq("single_product", last_prod, 64'd15);
        check_eq("single_tag", 64'(last_tag), 64'd2);

        // Extremes
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, w);
        wait_results(base + 2);
        check_eq("max_product", last_prod, 64'hFFFF_FFFE_0000_0001);
        push_op(32'h8000_0000, 32'd2, 4'd9, w);
        wait_results(base + 3);
        check_eq("msb_product", last_prod, 64'h0000_0001_0000_0000);

        // Fill with the consumer stalled; all five accepted back to back
        base = n_results;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op($urandom, $urandom, 4'(i), w);
            check_eq("fill_push_no_stall", 64'(w), 64'd0);
        end
        @(negedge clk);
        check_eq("full_in_ready_low", 64'(in_ready), 64'd0);

        // Backpressure: first result held, no further issue
        begin
            int k = 0;
            while (!out_valid && k < 200) begin
                @(posedge clk); k++;
            end
            check_eq("first_result_appears", 64'(out_valid), 64'd1);
        end
        s0 = n_starts;
        repeat (20) @(posedge clk);
        #1;
        check_eq("no_issue_under_backpressure", 64'(n_starts), 64'(s0));
        check_eq("in_ready_still_low", 64'(in_ready), 64'd0);
        begin
            int k = 0;
            while (n_results < base + 5 && k < 2000) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                k++;
            end
        end
        out_ready = 1'b1;
        wait_results(base + 5);
        check_eq("fill_last_tag", 64'(last_tag), 64'd4);

        // Wrap: 12 random ops with random gaps
        base = n_results;
        for (int i = 0; i < 12; i++) begin
            push_op($urandom, $urandom, 4'($urandom), w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_results(base + 12);
        check_eq("wrap_queue_drained", 64'(exp_prod_q.size()), 64'd0);

        // Reset while the multiplier is working, with ops still queued
        force_lat = 30;
        push_op(32'd11, 32'd13, 4'd1, w);
        push_op(32'd17, 32'd19, 4'd2, w);
        push_op(32'd23, 32'd29, 4'd3, w);
        begin
            int k = 0;
            while (!mul_busy && k < 100) begin
                @(posedge clk); k++;
            end
            check_eq("busy_before_reset", 64'(mul_busy), 64'd1);
        end
        #1 rst = 1'b1;
        exp_prod_q.delete();
        exp_tag_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        force_lat = 0;
        @(negedge clk);
        check_eq("midop_reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("midop_reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("midop_reset_mul_start", 64'(mul_start), 64'd0);
        s0 = n_starts;
        repeat (6) @(posedge clk);
        #1;
        check_eq("fifo_flushed_no_issue", 64'(n_starts), 64'(s0));
        base = n_results;
        push_op(32'd7, 32'd6, 4'd5, w);
        wait_results(base + 1);
        check_eq("post_reset_product", last_prod, 64'd42);
        check_eq("post_reset_tag", 64'(last_tag), 64'd5);

`ifdef MUL_ISSUE_STATS_EN
        repeat (2) @(posedge clk);
        #1;
        check_eq("stat_ops_after_reset", 64'(stat_ops), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
